test_status_ctrl: RTL and testbench

TEST_STATUS_CTRL -- requirements
Module: test_status_ctrl

---
 rtl/test_status_pkg.sv | 27 ++
 rtl/test_status_ctrl_sync_fifo.sv | 55 +++++
 rtl/test_status_ctrl.sv | 128 ++++++++++++
 tb/tb_test_status_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test_status_pkg.sv
// Shared definitions for the test status controller: register map, FSM states
// and the RESULT pass code.
package test_status_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam logic [7:0] REG_RESULT    = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_TIMEOUT   = 8'h08;
  localparam logic [7:0] REG_CYCLES    = 8'h0C;
  localparam logic [7:0] REG_CONSOLE   = 8'h10;
  localparam logic [7:0] REG_CON_LEVEL = 8'h14;

  localparam logic [31:0] RESULT_PASS_CODE = 32'h0000_0001;
  localparam logic [31:0] CYCLES_MAX       = 32'hFFFF_FFFF;

  function automatic logic [31:0] status_word(input logic tmo, input logic fail,
                                              input logic pass, input logic done);
    return {28'd0, tmo, fail, pass, done};
  endfunction

endpackage

// File: rtl/test_status_ctrl_sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_pop_s, do_push_s, full_s;

  assign full_s    = (count_q == LW'(DEPTH));
  assign do_pop_s  = pop_i && (count_q != LW'(0));
  assign do_push_s = push_i && (!full_s || do_pop_s);

  assign valid_o = (count_q != LW'(0));
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= LW'(0);
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/test_status_ctrl.sv
// Bus-mapped test status block: RESULT/TIMEOUT/CYCLES registers, a run-state
// watchdog FSM and a console character FIFO streamed to the bench.
module test_status_ctrl
  import test_status_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1000000,
  parameter int          CON_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o
);

  localparam int LVL_W = $clog2(CON_DEPTH) + 1;

  state_e      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic        done_q, pass_q, fail_q, tmo_q;
  logic        wr_s, rd_s, con_push_s;
  logic [LVL_W-1:0] con_level_s;

  assign gnt_o      = req_i;
  assign wr_s       = req_i && we_i;
  assign rd_s       = req_i && !we_i;
  assign con_push_s = wr_s && (addr_i == REG_CONSOLE);

  // Next-state logic: a nonzero RESULT write wins over a same-cycle timeout hit.
  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (cycles_q != CYCLES_MAX) cycles_d = cycles_q + 32'd1;
        else                        cycles_d = cycles_q;
        if (wr_s && (addr_i == REG_TIMEOUT)) timeout_d = wdata_i;
        else                                 timeout_d = timeout_q;
        if (wr_s && (addr_i == REG_RESULT) && (wdata_i != 32'd0)) begin
          if (wdata_i == RESULT_PASS_CODE) state_d = ST_PASS;
          else                             state_d = ST_FAIL;
        end else if ((timeout_q != 32'd0) && (cycles_q == timeout_q)) begin
          state_d = ST_TMO;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TMO: state_d = state_q;
      default: state_d = ST_RUN;
    endcase
  end

  // Read data mux.
  always_comb begin
    rdata_d = 32'd0;
    if (rd_s) begin
      case (addr_i)
        REG_STATUS:    rdata_d = status_word(tmo_q, fail_q, pass_q, done_q);
        REG_TIMEOUT:   rdata_d = timeout_q;
        REG_CYCLES:    rdata_d = cycles_q;
        REG_CON_LEVEL: rdata_d = 32'(con_level_s);
        default:       rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State, counters, status flags and read response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cycles_q  <= 32'd0;
      timeout_q <= TIMEOUT_DEFAULT;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
      done_q    <= (state_d != ST_RUN);
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      tmo_q     <= (state_d == ST_TMO);
      rvalid_q  <= rd_s;
      rdata_q   <= rdata_d;
    end
  end

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = tmo_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (con_push_s),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (con_ready_i),
    .valid_o (con_valid_o),
    .rdata_o (con_data_o),
    .level_o (con_level_s)
  );

endmodule

// File: tb/tb_test_status_ctrl.sv
// Self-checking bench for test_status_ctrl: register table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_test_status_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, con_ready_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, con_valid_o, done_o, pass_o, timeout_o;
  logic [31:0] rdata_o;
  logic [7:0]  con_data_o;

  int checks = 0;
  int errors = 0;

  test_status_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .con_valid_o(con_valid_o), .con_data_o(con_data_o), .con_ready_i(con_ready_i),
    .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Reference model: 0=RUN 1=PASS 2=FAIL 3=TMO, console as a byte queue.
  int          m_st;
  logic [31:0] m_cyc, m_tmo, m_rd;
  logic        m_rv;
  logic [7:0]  m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic rq, input logic we,
                            input logic [7:0] a, input logic [31:0] d, input logic rdy);
    int   pre_n, nst;
    logic popped;
    if (!r) begin
      m_st = 0; m_cyc = 32'd0; m_tmo = 32'd1000000; m_q.delete();
      m_rv = 1'b0; m_rd = 32'd0;
      return;
    end
    m_rv = rq && !we;
    m_rd = 32'd0;
    if (m_rv) begin
      case (a)
        8'h04:   m_rd = {28'd0, m_st == 3, m_st == 2, m_st == 1, m_st != 0};
        8'h08:   m_rd = m_tmo;
        8'h0C:   m_rd = m_cyc;
        8'h14:   m_rd = 32'(m_q.size());
        default: m_rd = 32'd0;
      endcase
    end
    pre_n  = m_q.size();
    popped = 1'b0;
    if (pre_n > 0 && rdy) begin
      void'(m_q.pop_front());
      popped = 1'b1;
    end
    if (rq && we && a == 8'h10 && (pre_n < 8 || popped)) m_q.push_back(d[7:0]);
    if (m_st == 0) begin
      nst = 0;
      if (rq && we && a == 8'h00 && d != 32'd0) nst = (d == 32'd1) ? 1 : 2;
      else if (m_tmo != 32'd0 && m_cyc == m_tmo) nst = 3;
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
      if (rq && we && a == 8'h08) m_tmo = d;
      m_st = nst;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input logic r, input logic rq, input logic we,
                      input logic [7:0] a, input logic [31:0] d, input logic rdy);
    rst = r; req_i = rq; we_i = we; addr_i = a; wdata_i = d; con_ready_i = rdy;
    #1;
    chk("gnt", {31'd0, gnt_o}, {31'd0, rq});
    @(posedge clk);
    model_edge(r, rq, we, a, d, rdy);
    @(negedge clk);
    chk("rvalid", {31'd0, rvalid_o}, {31'd0, m_rv});
    chk("rdata", rdata_o, m_rd);
    chk("done", {31'd0, done_o}, {31'd0, m_st != 0});
    chk("pass", {31'd0, pass_o}, {31'd0, m_st == 1});
    chk("timeout", {31'd0, timeout_o}, {31'd0, m_st == 3});
    chk("con_valid", {31'd0, con_valid_o}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("con_data", {24'd0, con_data_o}, {24'd0, m_q[0]});
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
  endtask
  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'd0, rdy);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic rdy);
    step(1'b1, 1'b1, 1'b1, a, d, rdy);
  endtask
  task automatic rd(input logic [7:0] a, input logic rdy);
    step(1'b1, 1'b1, 1'b0, a, 32'd0, rdy);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=hang expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int k;
    logic [7:0] a;

    tbl[0]  = '{1'b0, 8'h04, 32'd0,          1'b1, 32'd0};
    tbl[1]  = '{1'b0, 8'h08, 32'd0,          1'b1, 32'd1000000};
    tbl[2]  = '{1'b1, 8'h08, 32'd5000,       1'b0, 32'd0};
    tbl[3]  = '{1'b0, 8'h08, 32'd0,          1'b1, 32'd5000};
    tbl[4]  = '{1'b0, 8'h18, 32'd0,          1'b1, 32'd0};
    tbl[5]  = '{1'b0, 8'h14, 32'd0,          1'b1, 32'd0};
    tbl[6]  = '{1'b0, 8'h0C, 32'd0,          1'b1, 32'd6};
    tbl[7]  = '{1'b1, 8'h10, 32'h1234_5641,  1'b0, 32'd0};
    tbl[8]  = '{1'b0, 8'h14, 32'd0,          1'b1, 32'd1};
    tbl[9]  = '{1'b0, 8'h00, 32'd0,          1'b1, 32'd0};
    tbl[10] = '{1'b1, 8'h00, 32'd0,          1'b0, 32'd0};
    tbl[11] = '{1'b0, 8'h04, 32'd0,          1'b1, 32'd0};
    tbl[12] = '{1'b1, 8'h18, 32'hFFFF_FFFF,  1'b0, 32'd0};
    tbl[13] = '{1'b0, 8'h02, 32'd0,          1'b1, 32'd0};

    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 8'h00; wdata_i = 32'd0; con_ready_i = 1'b0;
    @(negedge clk);

    // Register table right after reset
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0);
      if (tbl[i].chk_rd) chk("tbl_rd", rdata_o, tbl[i].exp);
    end

    // Pass at cycle 50, CYCLES frozen
    do_reset();
    for (int i = 0; i < 50; i++) idle(1'b1);
    wr(8'h00, 32'd1, 1'b1);
    chk("pass_done", {30'd0, done_o, pass_o}, 32'd3);
    rd(8'h0C, 1'b1);
    v = rdata_o;
    chk("cyc_frozen_range", {31'd0, (v == 32'd50 || v == 32'd51)}, 32'd1);
    idle(1'b1);
    rd(8'h0C, 1'b1);
    chk("cyc_frozen_hold", rdata_o, v);

    // Fail code, then a later pass write is ignored
    do_reset();
    wr(8'h00, 32'hDEAD, 1'b1);
    chk("fail_flags", {30'd0, done_o, pass_o}, 32'd2);
    rd(8'h04, 1'b1);
    chk("fail_status", rdata_o, 32'd5);
    wr(8'h00, 32'd1, 1'b1);
    rd(8'h04, 1'b1);
    chk("fail_status_sticky", rdata_o, 32'd5);

    // Watchdog expiry at TIMEOUT=100
    do_reset();
    wr(8'h08, 32'd100, 1'b1);
    k = 0;
    while (!timeout_o && k < 300) begin idle(1'b1); k++; end
    chk("tmo_hit", {31'd0, timeout_o}, 32'd1);
    rd(8'h0C, 1'b1);
    chk("tmo_cycles", {31'd0, (rdata_o >= 32'd100 && rdata_o <= 32'd101)}, 32'd1);

    // TIMEOUT=0 disables the watchdog
    do_reset();
    wr(8'h08, 32'd0, 1'b1);
    for (int i = 0; i < 10000; i++) idle(1'b1);
    chk("tmo_disabled", {30'd0, timeout_o, done_o}, 32'd0);

    // RESULT write on the timeout-hit cycle wins
    do_reset();
    wr(8'h08, 32'd20, 1'b1);
    for (int i = 0; i < 19; i++) idle(1'b1);
    wr(8'h00, 32'd1, 1'b1);
    chk("prio_pass_tmo", {30'd0, pass_o, timeout_o}, 32'd2);

    // Console overflow drops and in-order drain
    do_reset();
    for (int i = 0; i < 10; i++) wr(8'h10, 32'(8'h41 + i), 1'b0);
    rd(8'h14, 1'b0);
    chk("con_level_full", rdata_o, 32'd8);
    idle(1'b0);
    idle(1'b0);
    chk("con_stable", {24'd0, con_data_o}, 32'h41);
    for (int i = 0; i < 8; i++) begin
      chk("con_drain", {23'd0, con_valid_o, con_data_o}, 32'h100 | 32'(8'h41 + i));
      idle(1'b1);
    end
    chk("con_empty", {31'd0, con_valid_o}, 32'd0);

    // Push and pop together when full, then reset mid-drain with a read in flight
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'h10, 32'(8'h61 + i), 1'b0);
    wr(8'h10, 32'h58, 1'b1);
    rd(8'h14, 1'b0);
    chk("con_level_pushpop", rdata_o, 32'd8);
    chk("con_head_after", {24'd0, con_data_o}, 32'h62);
    idle(1'b1);
    rd(8'h14, 1'b1);
    do_reset();
    chk("rst_con_valid", {30'd0, con_valid_o, rvalid_o}, 32'd0);
    rd(8'h14, 1'b1);
    chk("rst_con_level", rdata_o, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0: a = 8'h00;  1: a = 8'h04;  2: a = 8'h08;  3: a = 8'h0C;
        4: a = 8'h10;  5: a = 8'h14;  default: a = 8'($urandom_range(0, 255));
      endcase
      k = int'($urandom_range(0, 99));
      if ($urandom_range(0, 499) == 0) do_reset();
      else if (k < 2)  wr(8'h00, ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hDEAD, 1'($urandom_range(0, 1)));
      else if (k < 6)  wr(8'h08, 32'($urandom_range(0, 400)), 1'($urandom_range(0, 1)));
      else if (k < 40) wr(8'h10, $urandom, 1'($urandom_range(0, 1)));
      else if (k < 75) rd(a, 1'($urandom_range(0, 1)));
      else if (k < 80 && a != 8'h00) wr(a, $urandom, 1'($urandom_range(0, 1)));
      else idle(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
